// File: rtl/lsp_pkg.sv
// Shared constants and state encoding for the LSP root-search blocks.
package lsp_pkg;

  localparam int GRID_POINTS = 50;
  localparam int NUM_ROOTS   = 10;
  localparam int ADDR_W      = 6;
  localparam int Q15_W       = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_EVAL,
    S_WAIT,
    S_CHECK,
    S_REEVAL,
    S_RWAIT,
    S_FINISH
  } lsp_state_e;

endpackage

// File: rtl/lsp_sign_change.sv
// Sign-change detector: equivalent to L_mult(ylow, yhigh) <= 0 without a multiplier.
module lsp_sign_change (
  input  logic [lsp_pkg::Q15_W-1:0] ylow,
  input  logic [lsp_pkg::Q15_W-1:0] yhigh,
  output logic                      signChange
);

  assign signChange = (ylow[lsp_pkg::Q15_W-1] != yhigh[lsp_pkg::Q15_W-1]) |
                      (ylow == '0) | (yhigh == '0);

endmodule

// File: rtl/lsp_grid_search_ctrl.sv
// Grid-walk controller for the A(z)-to-LSP root search; sequences the shared Chebyshev evaluator.
// Optional watchdog abort enabled by defining LSP_GRID_WATCHDOG_EN.
module lsp_grid_search_ctrl #(
  parameter int GRID_POINTS = lsp_pkg::GRID_POINTS,
  parameter int NUM_ROOTS   = lsp_pkg::NUM_ROOTS,
  parameter int ADDR_W      = lsp_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] gridAddr,
  input  logic [15:0]       gridData,
  output logic              chebStart,
  output logic [15:0]       chebX,
  output logic              chebPolySel,
  input  logic              chebDone,
  input  logic [15:0]       chebIn,
  output logic              rootValid,
  output logic [15:0]       rootXLow,
  output logic [15:0]       rootXHigh,
  output logic [15:0]       rootYLow,
  output logic [15:0]       rootYHigh,
  output logic [3:0]        nf,
  output logic              busy,
  output logic              done,
  output logic              error
);
  import lsp_pkg::*;

  lsp_state_e        state_q, state_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic [3:0]        nf_q, nf_d;
  logic              sel_q, sel_d;
  logic [15:0]       xlow_q, xlow_d, xhigh_q, xhigh_d;
  logic [15:0]       ylow_q, ylow_d, yhigh_q, yhigh_d;
  logic              sign_change;
  logic              timeout;

  lsp_sign_change u_sign (
    .ylow      (ylow_q),
    .yhigh     (yhigh_q),
    .signChange(sign_change)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      nf_q    <= '0;
      sel_q   <= 1'b0;
      xlow_q  <= '0;
      xhigh_q <= '0;
      ylow_q  <= '0;
      yhigh_q <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      nf_q    <= nf_d;
      sel_q   <= sel_d;
      xlow_q  <= xlow_d;
      xhigh_q <= xhigh_d;
      ylow_q  <= ylow_d;
      yhigh_q <= yhigh_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    nf_d      = nf_q;
    sel_d     = sel_q;
    xlow_d    = xlow_q;
    xhigh_d   = xhigh_q;
    ylow_d    = ylow_q;
    yhigh_d   = yhigh_q;
    chebStart = 1'b0;
    rootValid = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        j_d     = '0;
        nf_d    = '0;
        sel_d   = 1'b0;
        state_d = S_FETCH;
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        xhigh_d = gridData;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        chebStart = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (chebDone) begin
          yhigh_d = chebIn;
          if (j_q == '0) begin
            xlow_d  = xhigh_q;
            ylow_d  = chebIn;
            j_d     = ADDR_W'(1);
            state_d = S_FETCH;
          end else begin
            state_d = S_CHECK;
          end
        end else if (timeout) begin
          state_d = S_FINISH;
        end
      end
      S_CHECK: begin
        if (sign_change) begin
          rootValid = 1'b1;
          nf_d      = nf_q + 4'd1;
          sel_d     = ~sel_q;
          if (nf_q + 4'd1 == 4'(NUM_ROOTS)) begin
            state_d = S_FINISH;
          end else begin
            xlow_d  = xhigh_q;
            state_d = S_REEVAL;
          end
        end else begin
          xlow_d = xhigh_q;
          ylow_d = yhigh_q;
          if (j_q == ADDR_W'(GRID_POINTS)) begin
            state_d = S_FINISH;
          end else begin
            j_d     = j_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_REEVAL: begin
        chebStart = 1'b1;
        state_d   = S_RWAIT;
      end
      S_RWAIT: begin
        if (chebDone) begin
          ylow_d = chebIn;
          if (j_q == ADDR_W'(GRID_POINTS)) begin
            state_d = S_FINISH;
          end else begin
            j_d     = j_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end else if (timeout) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef LSP_GRID_WATCHDOG_EN
  logic [7:0] wd_q;
  logic       err_q;

  // Counter starts at the chebStart cycle so the abort lands 256 cycles after it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == S_EVAL || state_q == S_REEVAL ||
          state_q == S_WAIT || state_q == S_RWAIT)
        wd_q <= wd_q + 8'd1;
      else
        wd_q <= '0;
      if (state_q == S_IDLE && start)
        err_q <= 1'b0;
      else if (timeout && !chebDone && (state_q == S_WAIT || state_q == S_RWAIT))
        err_q <= 1'b1;
    end
  end

  assign timeout = (wd_q == '1);
  assign error   = err_q;
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  assign gridAddr    = j_q;
  assign chebX       = (state_q == S_REEVAL || state_q == S_RWAIT) ? xlow_q : xhigh_q;
  assign chebPolySel = sel_q;
  assign rootXLow    = xlow_q;
  assign rootXHigh   = xhigh_q;
  assign rootYLow    = ylow_q;
  assign rootYHigh   = yhigh_q;
  assign nf          = nf_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_FINISH);

endmodule

// File: doc/lsp_grid_search_ctrl.md
Name: lsp_grid_search_ctrl

Overview:
- Controller for the A(z)-to-LSP root search.
- Walks the 51-entry cosine grid ROM and sequences the shared Chebyshev evaluator (start/done handshake) at each grid point.
- Detects sign changes between consecutive evaluations, alternating F1/F2 after each root.
- Emits root brackets to the downstream interpolation/LSP-store stage.

Parameters:
- GRID_POINTS, 50: index of the last grid entry; grid holds GRID_POINTS+1 entries.
- NUM_ROOTS, 10: LSP order; search stops after this many roots.
- ADDR_W, 6: grid ROM address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a search (ignored unless IDLE)
- gridAddr  out  ADDR_W  grid ROM address
- gridData  in  16  grid ROM data, valid one cycle after gridAddr
- chebStart  out  1  one-cycle pulse to Chebyshev evaluator
- chebX  out  16  x operand; held stable from chebStart until chebDone
- chebPolySel  out  1  0 = F1 coefficients, 1 = F2
- chebDone  in  1  one-cycle pulse; chebIn valid this cycle
- chebIn  in  16  polynomial value (Q15, signed)
- rootValid  out  1  one-cycle pulse per root found
- rootXLow, rootXHigh  out  16  bracketing grid x values
- rootYLow, rootYHigh  out  16  polynomial values at the bracket ends
- nf  out  4  roots found so far
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at search end
- error  out  1  watchdog abort flag (only with the optional feature)

Behaviour:
- Reset (reset==0 at clk edge): state IDLE; all outputs 0; j=0, nf=0, polySel=0.
  - Mid-search reset aborts immediately with no done pulse.
- States: IDLE, FETCH, LATCH, EVAL, WAIT, CHECK, REEVAL, RWAIT, FINISH.
- IDLE: on start, clear j, nf, polySel, then go to FETCH with gridAddr=0. Set busy.
- FETCH: hold gridAddr=j for one cycle (ROM latency), then go to LATCH.
- LATCH: register xhigh=gridData, then go to EVAL.
- EVAL: drive chebX=xhigh, chebStart=1 for exactly one cycle, then go to WAIT.
- WAIT: wait for chebDone and register yhigh=chebIn.
  - If j==0: set xlow=xhigh, ylow=yhigh, j=1, go to FETCH.
  - Otherwise go to CHECK.
- CHECK: signChange = (ylow[15]!=yhigh[15]) | (ylow==0) | (yhigh==0). This is equivalent to L_mult(ylow,yhigh)<=0; no multiplier is used.
  - signChange=1: pulse rootValid with xlow/xhigh/ylow/yhigh; nf++; toggle polySel.
    - If nf+1==NUM_ROOTS, go to FINISH.
    - Otherwise set xlow=xhigh, go to REEVAL.
  - signChange=0: set xlow=xhigh, ylow=yhigh.
    - If j==GRID_POINTS, go to FINISH.
    - Otherwise j++, go to FETCH.
- REEVAL/RWAIT: re-evaluate the new polynomial at xlow (pulse chebStart, chebX=xlow), then ylow=chebIn on chebDone.
  - If j==GRID_POINTS, go to FINISH.
  - Otherwise j++, go to FETCH.
- FINISH: done=1 for one cycle, busy=0, go to IDLE. nf holds its value until the next start.
- chebPolySel changes only in CHECK and is never changed while the evaluator is busy.
- chebDone outside WAIT/RWAIT is ignored. start while busy is ignored.
- nf<NUM_ROOTS at done is legal; the downstream stage substitutes old LSPs.

Optional Feature:
- Macro LSP_GRID_WATCHDOG_EN.
- Defined: an 8-bit counter runs in WAIT/RWAIT. If it reaches 255 with no chebDone, assert error (sticky until next start) and go to FINISH (done pulses).
- Undefined: no counter; error is tied to 0; WAIT/RWAIT wait indefinitely.

Decomposition:
- Shared package lsp_pkg holds:
  - state encoding localparams;
  - GRID_POINTS, NUM_ROOTS, ADDR_W;
  - Q15 word width constant (16).
- One sub-module, lsp_sign_change: combinational; inputs ylow, yhigh; output signChange.
  - Reused by the later bisection/interpolation block.

Test Plan:
- Reset mid-WAIT (j=7): drive reset=0 for one cycle. Expect IDLE, busy=0, no done, nf=0, all outputs 0. A following start restarts at gridAddr=0.
- Bench model returns chebIn=+1000 at j<=4 and -1000 after, for both polys. Expect rootValid with xLow=grid[4], xHigh=grid[5], yLow=1000, yHigh=-1000.
  - Then chebPolySel=1 and one REEVAL at grid[5].
- chebIn==0 exactly at j=3 (ylow=+500). Expect a root at bracket (grid[2],grid[3]), yHigh=0.
- Model alternates sign every grid point, 51 points. Expect 10 rootValid pulses, then done immediately after the 10th (nf=10) without reading further grid entries.
- Monotonic positive polynomial. Expect 51 evaluations, 0 roots, done with nf=0. gridAddr sequence is 0..50 exactly once each.
- LSP_GRID_WATCHDOG_EN defined, chebDone withheld. Expect error=1 and done at 256 cycles after chebStart.
  - Undefined: busy remains 1 through 1000 cycles.
